// File: rtl/axi_stream_to_data.sv
// AXI-Stream sink feeding a show-ahead FIFO, with frame counting and an optional
// sticky framing check enabled by defining AXIS_FRAME_CHECK_EN.
module axi_stream_to_data #(
  parameter int DATA_WIDTH = 1024,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  S_AXIS_tvalid,
  output logic                  S_AXIS_tready,
  input  logic [DATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                  S_AXIS_tlast,
  input  logic [31:0]           tlast_interval,
  input  logic                  read_enable,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] data_pkt,
  output logic                  data_last,
  output logic [31:0]           frame_count,
  output logic                  frame_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                r_tready;
  logic [31:0]         r_beat_index;
  logic [31:0]         r_frame_count;

  logic                w_push;
  logic                w_pop;
  logic                w_not_empty;
  logic [CW-1:0]       w_count_next;

  assign w_not_empty  = (r_count != '0);
  assign w_push       = S_AXIS_tvalid & r_tready;
  assign w_pop        = read_enable & w_not_empty;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  // NOTE: the storage array has no reset; emptiness is tracked by r_count alone,
  // so stale entries are never visible and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {S_AXIS_tlast, S_AXIS_tdata};
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_tready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count  <= w_count_next;
      // Ready looks at post-edge occupancy so it drops in the same edge the FIFO fills.
      r_tready <= (w_count_next < CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_index  <= '0;
      r_frame_count <= '0;
    end else if (w_push) begin
      if (S_AXIS_tlast) begin
        r_beat_index  <= '0;
        r_frame_count <= r_frame_count + 32'd1;
      end else begin
        r_beat_index  <= r_beat_index + 32'd1;
      end
    end
  end

  assign S_AXIS_tready = r_tready;
  assign data_valid    = w_not_empty;
  // Head is masked while empty so the unreset array never leaks to the outputs.
  assign data_pkt      = w_not_empty ? r_mem[r_rd_ptr][DATA_WIDTH-1:0] : '0;
  assign data_last     = w_not_empty & r_mem[r_rd_ptr][DATA_WIDTH];
  assign frame_count   = r_frame_count;

`ifdef AXIS_FRAME_CHECK_EN
  logic r_frame_error;
  logic w_frame_bad;

  assign w_frame_bad = S_AXIS_tlast ? (r_beat_index != tlast_interval)
                                    : (r_beat_index == tlast_interval);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_error <= 1'b0;
    end else if (w_push && w_frame_bad) begin
      r_frame_error <= 1'b1;
    end
  end

  assign frame_error = r_frame_error;
`else
  logic w_unused_frame;

  assign w_unused_frame = ^{tlast_interval, r_beat_index};
  assign frame_error    = 1'b0;
`endif

endmodule

// File: tb/tb_axi_stream_to_data.sv
// Directed bench for axi_stream_to_data: reset, single beat, empty pops, fill
// back-pressure, concurrent push/pop, framing and mid-cycle reset.
module tb_axi_stream_to_data;

  localparam int DW    = 32;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          S_AXIS_tvalid = 1'b0;
  logic          S_AXIS_tready;
  logic [DW-1:0] S_AXIS_tdata = '0;
  logic          S_AXIS_tlast = 1'b0;
  logic [31:0]   tlast_interval = '0;
  logic          read_enable = 1'b0;
  logic          data_valid;
  logic [DW-1:0] data_pkt;
  logic          data_last;
  logic [31:0]   frame_count;
  logic          frame_error;

  always #5 clk = ~clk;

  axi_stream_to_data #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .S_AXIS_tvalid  (S_AXIS_tvalid),
    .S_AXIS_tready  (S_AXIS_tready),
    .S_AXIS_tdata   (S_AXIS_tdata),
    .S_AXIS_tlast   (S_AXIS_tlast),
    .tlast_interval (tlast_interval),
    .read_enable    (read_enable),
    .data_valid     (data_valid),
    .data_pkt       (data_pkt),
    .data_last      (data_last),
    .frame_count    (frame_count),
    .frame_error    (frame_error)
  );

`ifdef AXIS_FRAME_CHECK_EN
  localparam logic FRAME_CHECK = 1'b1;
`else
  localparam logic FRAME_CHECK = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DW:0]  m_q [$];
  logic [31:0]  m_bi     = '0;
  logic [31:0]  m_frames = '0;
  logic         m_err    = 1'b0;
  logic         m_ready  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [DW:0] head;
    head = (m_q.size() != 0) ? m_q[0] : '0;
    check({tag, ".tready"},      64'(S_AXIS_tready), 64'(m_ready));
    check({tag, ".data_valid"},  64'(data_valid),    64'(m_q.size() != 0));
    check({tag, ".data_pkt"},    64'(data_pkt),      64'(head[DW-1:0]));
    check({tag, ".data_last"},   64'(data_last),     64'(head[DW]));
    check({tag, ".frame_count"}, 64'(frame_count),   64'(m_frames));
    check({tag, ".frame_error"}, 64'(frame_error),   64'(m_err & FRAME_CHECK));
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare outputs.
  task automatic cycle(input string tag, input logic push, input logic [DW-1:0] data,
                       input logic last, input logic pop);
    logic acc, rd;
    S_AXIS_tvalid = push;
    S_AXIS_tdata  = data;
    S_AXIS_tlast  = last;
    read_enable   = pop;
    acc = push && m_ready;
    rd  = pop && (m_q.size() != 0);
    @(posedge clk);
    #1;
    if (rd) void'(m_q.pop_front());
    if (acc) begin
      m_q.push_back({last, data});
      if ((last && m_bi != tlast_interval) || (!last && m_bi == tlast_interval)) m_err = 1'b1;
      if (last) begin
        m_bi     = '0;
        m_frames = m_frames + 32'd1;
      end else begin
        m_bi = m_bi + 32'd1;
      end
    end
    m_ready = (m_q.size() < DEPTH);
    check_outputs(tag);
  endtask

  // Push with tlast placed where a well-formed frame expects it.
  task automatic push_auto(input string tag, input logic [DW-1:0] data, input logic pop);
    cycle(tag, 1'b1, data, (m_bi == tlast_interval), pop);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.tready",      64'(S_AXIS_tready), 64'd0);
    check("rst.data_valid",  64'(data_valid),    64'd0);
    check("rst.data_pkt",    64'(data_pkt),      64'd0);
    check("rst.data_last",   64'(data_last),     64'd0);
    check("rst.frame_count", 64'(frame_count),   64'd0);
    check("rst.frame_error", 64'(frame_error),   64'd0);
    rst = 1'b0;
    idle("release");
    check("release.tready_first_edge", 64'(S_AXIS_tready), 64'd1);

    // Single beat, interval 0
    tlast_interval = 32'd0;
    cycle("single", 1'b1, 32'hA5, 1'b1, 1'b0);
    check("single.valid",       64'(data_valid),  64'd1);
    check("single.pkt",         64'(data_pkt),    64'hA5);
    check("single.last",        64'(data_last),   64'd1);
    check("single.frame_count", 64'(frame_count), 64'd1);
    check("single.frame_error", 64'(frame_error), 64'd0);
    cycle("single_pop", 1'b0, '0, 1'b0, 1'b1);
    check("single_pop.valid", 64'(data_valid), 64'd0);

    // Pop on empty is ignored
    for (int i = 0; i < 3; i++) cycle("empty_pop", 1'b0, '0, 1'b0, 1'b1);
    cycle("one_push", 1'b1, 32'h1, 1'b1, 1'b0);
    check("one_push.pkt", 64'(data_pkt), 64'h1);
    cycle("one_pop", 1'b0, '0, 1'b0, 1'b1);
    check("one_pop.valid", 64'(data_valid), 64'd0);

    // Fill to full, then a held 33rd beat
    tlast_interval = 32'd3;
    for (int i = 0; i < DEPTH; i++) push_auto("fill", 32'h100 + 32'(i), 1'b0);
    check("fill.tready_full", 64'(S_AXIS_tready), 64'd0);
    for (int i = 0; i < 3; i++) push_auto("held", 32'h200, 1'b0);
    check("held.head",        64'(data_pkt),    64'h100);
    check("held.frame_count", 64'(frame_count), 64'd10);
    push_auto("held_pop", 32'h200, 1'b1);
    check("held_pop.tready", 64'(S_AXIS_tready), 64'd1);
    check("held_pop.head",   64'(data_pkt),      64'h101);
    push_auto("accept33", 32'h200, 1'b0);
    check("accept33.tready", 64'(S_AXIS_tready), 64'd0);
    for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, '0, 1'b0, 1'b1);
    check("drain.valid", 64'(data_valid), 64'd0);

    // Concurrent push/pop at occupancy 5
    for (int k = 0; k < 5; k++) push_auto("pre5", 32'h300 + 32'(k), 1'b0);
    for (int k = 0; k < 10; k++) push_auto("pushpop", 32'h400 + 32'(k), 1'b1);
    check("pushpop.head", 64'(data_pkt), 64'h405);
    for (int k = 0; k < 5; k++) cycle("drain5", 1'b0, '0, 1'b0, 1'b1);
    check("drain5.empty", 64'(data_valid), 64'd0);

    // Framing, interval 3
    for (int k = 0; k < 4; k++) push_auto("frame_ok", 32'h500 + 32'(k), 1'b0);
    check("frame_ok.error", 64'(frame_error), 64'd0);
    cycle("frame_bad", 1'b1, 32'h510, 1'b0, 1'b0);
    cycle("frame_bad", 1'b1, 32'h511, 1'b0, 1'b0);
    cycle("frame_bad", 1'b1, 32'h512, 1'b1, 1'b0);
    check("frame_bad.error", 64'(frame_error), 64'(FRAME_CHECK));
    for (int k = 0; k < 4; k++) push_auto("frame_after", 32'h520 + 32'(k), 1'b0);
    check("frame_after.sticky", 64'(frame_error), 64'(FRAME_CHECK));
    for (int k = 0; k < 11; k++) cycle("drain_frame", 1'b0, '0, 1'b0, 1'b1);

    // Mid-cycle reset with 10 entries stored and a beat presented
    for (int k = 0; k < 10; k++) push_auto("pre_rst", 32'h600 + 32'(k), 1'b0);
    check("pre_rst.valid", 64'(data_valid), 64'd1);
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata  = 32'h6FF;
    S_AXIS_tlast  = 1'b1;
    #3 rst = 1'b1;
    #1;
    check("async_rst.valid",       64'(data_valid),    64'd0);
    check("async_rst.tready",      64'(S_AXIS_tready), 64'd0);
    check("async_rst.frame_count", 64'(frame_count),   64'd0);
    check("async_rst.frame_error", 64'(frame_error),   64'd0);
    check("async_rst.pkt",         64'(data_pkt),      64'd0);
    @(posedge clk);
    #1;
    check("rst_edge.tready", 64'(S_AXIS_tready), 64'd0);
    check("rst_edge.valid",  64'(data_valid),    64'd0);
    S_AXIS_tvalid = 1'b0;
    m_q.delete();
    m_bi     = '0;
    m_frames = '0;
    m_err    = 1'b0;
    m_ready  = 1'b0;
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    check_outputs("post_rst");
    check("post_rst.tready", 64'(S_AXIS_tready), 64'd1);
    cycle("post_rst_push", 1'b1, 32'h77, 1'b1, 1'b0);
    check("post_rst_push.pkt", 64'(data_pkt), 64'h77);
    cycle("post_rst_pop", 1'b0, '0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_stream_to_data.md
AXI_STREAM_TO_DATA -- requirements
Module: axi_stream_to_data

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1024: beat and packet width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 32: entries, power of two, minimum 4.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port S_AXIS_tvalid, input, 1: upstream beat valid.
REQ-007 SHALL have port S_AXIS_tready, output, 1: registered ready.
REQ-008 SHALL have port S_AXIS_tdata, input, DATA_WIDTH: beat payload.
REQ-009 SHALL have port S_AXIS_tlast, input, 1: last beat of frame.
REQ-010 SHALL have port tlast_interval, input, 32: expected beats per frame minus 1.
REQ-011 SHALL have port read_enable, input, 1: consumer pop request.
REQ-012 SHALL have port data_valid, output, 1: FIFO non-empty.
REQ-013 SHALL have port data_pkt, output, DATA_WIDTH: head-of-FIFO payload, show-ahead.
REQ-014 SHALL have port data_last, output, 1: tlast stored with the head entry.
REQ-015 SHALL have port frame_count, output, 32: frames accepted (beats with tlast=1).
REQ-016 SHALL have port frame_error, output, 1: sticky framing-error flag.

Function
REQ-017 SHALL accept a beat on a rising edge with S_AXIS_tvalid=1 and S_AXIS_tready=1; SHALL write {tlast, tdata} into the FIFO on that edge.
REQ-018 SHALL drive S_AXIS_tready from a register set to 1 iff the occupancy after the current edge is below FIFO_DEPTH; it SHALL never be 1 while the FIFO is full.
REQ-019 SHALL drive data_valid = (count != 0), and data_pkt/data_last = FIFO head; read-after-write latency is 1 cycle (write edge N, data_valid high after edge N).
REQ-020 SHALL pop on a rising edge with read_enable=1 and data_valid=1; read_enable while empty SHALL be ignored, with no pointer or count change.
REQ-021 SHALL handle simultaneous push and pop in one cycle: count unchanged, both pointers advance.
REQ-022 SHALL wrap read and write pointers modulo FIFO_DEPTH; count width SHALL be log2(FIFO_DEPTH)+1.
REQ-023 SHALL keep a 32-bit beat_index, reset 0, incremented per accepted beat and cleared to 0 on an accepted beat with tlast=1.
REQ-024 SHALL increment frame_count per accepted tlast=1 beat, wrapping 0xFFFFFFFF to 0.
REQ-025 SHALL leave the FIFO write of a beat unaffected by frame checks; data is never dropped by this block.

Reset
REQ-026 SHALL, while rst=1, hold S_AXIS_tready=0, data_valid=0, data_pkt=0, data_last=0, frame_count=0, frame_error=0, with pointers, count and beat_index at 0.
REQ-027 SHALL raise S_AXIS_tready on the first rising edge after rst deasserts.
REQ-028 SHALL discard all FIFO contents on reset mid-operation; a beat presented at the edge rst asserts SHALL not be accepted.

Configuration
REQ-029 SHALL implement the framing check only when macro AXIS_FRAME_CHECK_EN is defined.
REQ-030 SHALL, with AXIS_FRAME_CHECK_EN defined, set frame_error on an accepted beat where (tlast=1 and beat_index != tlast_interval) or (tlast=0 and beat_index == tlast_interval); the flag stays 1 until reset.
REQ-031 SHALL, without AXIS_FRAME_CHECK_EN, tie frame_error to 0 and ignore tlast_interval; all other behaviour is identical.

Verification
REQ-032 SHALL cover single beat: tdata=0xA5, tlast=1, tlast_interval=0 -> data_valid=1 one cycle later, data_pkt=0xA5, data_last=1, frame_count=1, frame_error=0.
REQ-033 SHALL cover fill: read_enable=0, 32 beats -> S_AXIS_tready=0 after the 32nd accept; a 33rd beat held valid is not accepted until one pop, then it is accepted.
REQ-034 SHALL cover simultaneous push/pop at count=5 for 10 cycles -> count stays 5 and output order matches input order.
REQ-035 SHALL cover framing with AXIS_FRAME_CHECK_EN defined, tlast_interval=3: frame of 4 beats -> frame_error=0; next frame tlast on beat 3 -> frame_error=1 and stays 1.
REQ-036 SHALL cover reset with 10 entries stored, rst pulsed asynchronously mid-cycle -> data_valid=0 and S_AXIS_tready=0 immediately, frame_count=0, tready=1 on the first edge after release.
REQ-037 SHALL cover pop-on-empty: read_enable=1 for 3 cycles with the FIFO empty -> no change, then one beat 0x1 is read correctly.
